// File: rtl/rng_health_monitor.sv
// Online health gate for a raw RNG sample stream: repetition-count and adaptive-proportion
// tests on whole samples. Only samples taken while healthy are forwarded; failures latch until clear_i.
module rng_health_monitor #(
  parameter int N         = 32,
  parameter int RctCutoff = 4,
  parameter int AptWindow = 512,
  parameter int AptCutoff = 13,
  parameter int Startup   = 1024
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         valid_i,
  input  logic [N-1:0] data_i,
  input  logic         clear_i,
  output logic         valid_o,
  output logic [N-1:0] data_o,
  output logic         healthy_o,
  output logic         rct_fail_o,
  output logic         apt_fail_o
);
  localparam int RW = $clog2(RctCutoff + 1);
  localparam int AW = $clog2(AptCutoff + 1);
  localparam int IW = $clog2(AptWindow);
  localparam int SW = $clog2(Startup + 1);

  typedef enum logic [1:0] {ST_STARTUP, ST_RUN, ST_FAILED} state_e;
  state_e state_q, state_d;

  logic [N-1:0]  last_r, ref_r;
  logic [RW-1:0] rct_cnt, rct_nxt;
  logic [AW-1:0] apt_cnt, apt_nxt;
  logic [IW-1:0] apt_idx;
  logic [SW-1:0] su_cnt;
  logic          accept, rct_hit, apt_hit, fail_now, su_done, fwd;

  // clear_i wins over a same-cycle sample; FAILED freezes every counter
  assign accept   = valid_i & ~clear_i & (state_q != ST_FAILED);
  assign su_done  = (su_cnt == SW'(Startup - 1));

  always_comb begin
    rct_nxt = RW'(1);
    if (rct_cnt != '0 && data_i == last_r)
      rct_nxt = (rct_cnt == RW'(RctCutoff)) ? rct_cnt : rct_cnt + RW'(1);
    apt_nxt = apt_cnt;
    if (apt_idx == '0)
      apt_nxt = AW'(1);
    else if (data_i == ref_r && apt_cnt != AW'(AptCutoff))
      apt_nxt = apt_cnt + AW'(1);
  end

  assign rct_hit  = accept && (rct_nxt == RW'(RctCutoff));
  assign apt_hit  = accept && (apt_nxt == AW'(AptCutoff));
  assign fail_now = rct_hit | apt_hit;
  assign fwd      = accept & ~fail_now & (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    if (clear_i)
      state_d = ST_STARTUP;
    else if (accept) begin
      if (fail_now)
        state_d = ST_FAILED;
      else if (state_q == ST_STARTUP && su_done)
        state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_STARTUP;
      last_r  <= '0;
      ref_r   <= '0;
      rct_cnt <= '0;
      apt_cnt <= '0;
      apt_idx <= '0;
      su_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (clear_i) begin
        rct_cnt <= '0;
        apt_cnt <= '0;
        apt_idx <= '0;
        su_cnt  <= '0;
      end else if (accept) begin
        rct_cnt <= rct_nxt;
        last_r  <= data_i;
        apt_cnt <= apt_nxt;
        if (apt_idx == '0) ref_r <= data_i;
        apt_idx <= (apt_idx == IW'(AptWindow - 1)) ? '0 : apt_idx + IW'(1);
        if (state_q == ST_STARTUP) su_cnt <= su_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_o    <= 1'b0;
      data_o     <= '0;
      healthy_o  <= 1'b0;
      rct_fail_o <= 1'b0;
      apt_fail_o <= 1'b0;
    end else begin
      valid_o   <= fwd;
      if (fwd) data_o <= data_i;
      healthy_o <= (state_d == ST_RUN);
      if (clear_i) begin
        rct_fail_o <= 1'b0;
        apt_fail_o <= 1'b0;
      end else begin
        if (rct_hit) rct_fail_o <= 1'b1;
        if (apt_hit) apt_fail_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rng_health_monitor.sv
// Directed bench for rng_health_monitor: per-cycle vector table plus hand sequences for
// async reset and gapped input.
module tb_rng_health_monitor;
  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       valid_i, clear_i;
  logic [7:0] data_i;
  logic       valid_o, healthy_o, rct_fail_o, apt_fail_o;
  logic [7:0] data_o;

  int checks = 0;
  int errors = 0;

  rng_health_monitor #(.N(8), .RctCutoff(3), .AptWindow(8), .AptCutoff(4), .Startup(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .data_i(data_i), .clear_i(clear_i),
    .valid_o(valid_o), .data_o(data_o), .healthy_o(healthy_o),
    .rct_fail_o(rct_fail_o), .apt_fail_o(apt_fail_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       vi, ci;
    logic [7:0] di;
    logic [11:0] exp;  // {valid_o, data_o, healthy_o, rct_fail_o, apt_fail_o}
  } vec_t;
  vec_t tbl[$];

  function automatic logic [11:0] pk(logic v, logic [7:0] d, logic h, logic r, logic a);
    return {v, d, h, r, a};
  endfunction

  task automatic add(logic vi, logic ci, logic [7:0] di, logic v, logic [7:0] d, logic h, logic r, logic a);
    vec_t e;
    e.vi = vi; e.ci = ci; e.di = di; e.exp = pk(v, d, h, r, a);
    tbl.push_back(e);
  endtask

  task automatic chk(string name, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {v,d,h,r,a}=%h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return pk(valid_o, data_o, healthy_o, rct_fail_o, apt_fail_o);
  endfunction

  task automatic cyc(logic vi, logic ci, logic [7:0] di);
    @(negedge clk_i);
    valid_i = vi; clear_i = ci; data_i = di;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rstn_i = 1'b0; valid_i = 1'b0; clear_i = 1'b0; data_i = '0;
    #1;
    chk("reset_values", outs(), 12'h000);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;

    // startup with an idle gap, then forwarding
    add(1,0,8'h01, 0,8'h00,0,0,0);
    add(1,0,8'h02, 0,8'h00,0,0,0);
    add(0,0,8'h02, 0,8'h00,0,0,0);
    add(1,0,8'h03, 0,8'h00,0,0,0);
    add(1,0,8'h04, 0,8'h00,1,0,0);
    add(1,0,8'h05, 1,8'h05,1,0,0);
    add(0,0,8'h05, 0,8'h05,1,0,0);
    add(1,0,8'h06, 1,8'h06,1,0,0);
    add(1,0,8'h07, 1,8'h07,1,0,0);
    add(1,0,8'h08, 1,8'h08,1,0,0);
    // APT: new window starts here, ref=0xA, fourth 0xA is the 7th sample
    add(1,0,8'h0A, 1,8'h0A,1,0,0);
    add(1,0,8'h01, 1,8'h01,1,0,0);
    add(1,0,8'h0A, 1,8'h0A,1,0,0);
    add(1,0,8'h02, 1,8'h02,1,0,0);
    add(1,0,8'h0A, 1,8'h0A,1,0,0);
    add(1,0,8'h03, 1,8'h03,1,0,0);
    add(1,0,8'h0A, 0,8'h03,0,0,1);
    add(1,0,8'h05, 0,8'h03,0,0,1);
    // clear collides with a sample: sample dropped, startup needs four more
    add(1,1,8'h07, 0,8'h03,0,0,0);
    add(1,0,8'h01, 0,8'h03,0,0,0);
    add(1,0,8'h02, 0,8'h03,0,0,0);
    add(1,0,8'h03, 0,8'h03,0,0,0);
    add(1,0,8'h04, 0,8'h03,1,0,0);
    // RCT: 9,9 forwarded, third 9 fails
    add(1,0,8'h09, 1,8'h09,1,0,0);
    add(1,0,8'h09, 1,8'h09,1,0,0);
    add(1,0,8'h09, 0,8'h09,0,1,0);
    add(1,0,8'h04, 0,8'h09,0,1,0);
    add(0,1,8'h00, 0,8'h09,0,0,0);
    // APT variant: three matches then the window wraps, no failure
    add(1,0,8'h0A, 0,8'h09,0,0,0);
    add(1,0,8'h01, 0,8'h09,0,0,0);
    add(1,0,8'h0A, 0,8'h09,0,0,0);
    add(1,0,8'h02, 0,8'h09,1,0,0);
    add(1,0,8'h0A, 1,8'h0A,1,0,0);
    add(1,0,8'h03, 1,8'h03,1,0,0);
    add(1,0,8'h0B, 1,8'h0B,1,0,0);
    add(1,0,8'h0C, 1,8'h0C,1,0,0);
    add(1,0,8'h0D, 1,8'h0D,1,0,0);
    add(1,0,8'h0A, 1,8'h0A,1,0,0);
    add(1,0,8'h0A, 1,8'h0A,1,0,0);

    foreach (tbl[i]) begin
      cyc(tbl[i].vi, tbl[i].ci, tbl[i].di);
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // async reset between edges, in RUN with valid_o high
    @(posedge clk_i);
    #3 rstn_i = 1'b0;
    #1 chk("async_reset", outs(), 12'h000);
    @(negedge clk_i);
    valid_i = 1'b0;
    rstn_i  = 1'b1;

    // gapped samples 1..5; idle cycles hold data that would match if counted
    for (int s = 1; s <= 5; s++) begin
      int gap = $urandom_range(0, 3);
      repeat (gap) begin
        cyc(0, 0, 8'(s - 1));
        chk("gap_idle", {valid_o, 11'h0}, 12'h000);
      end
      cyc(1, 0, 8'(s));
      case (s)
        4:       chk("gap_s4", outs(), pk(0, 8'h00, 1, 0, 0));
        5:       chk("gap_s5", outs(), pk(1, 8'h05, 1, 0, 0));
        default: chk($sformatf("gap_s%0d", s), outs(), pk(0, 8'h00, 0, 0, 0));
      endcase
    end
    cyc(1, 0, 8'h09);
    chk("gap_rct1", outs(), pk(1, 8'h09, 1, 0, 0));
    repeat (3) cyc(0, 0, 8'h09);
    chk("gap_rct_idle", outs(), pk(0, 8'h09, 1, 0, 0));
    cyc(1, 0, 8'h09);
    chk("gap_rct2", outs(), pk(1, 8'h09, 1, 0, 0));
    cyc(0, 0, 8'h09);
    cyc(1, 0, 8'h09);
    chk("gap_rct3", outs(), pk(0, 8'h09, 0, 1, 0));
    cyc(1, 0, 8'h11);
    chk("gap_failed_hold", outs(), pk(0, 8'h09, 0, 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rng_health_monitor.md
# rng_health_monitor

Online health tester and gate for the ring-oscillator/cellular-automaton random number generator output. It consumes raw N-bit samples, runs a repetition-count test (RCT) and an adaptive-proportion test (APT) on whole samples, and forwards only samples taken while the source is healthy. A failure latches until software or a supervisor issues `clear_i`. It sits between the generator and any consumer of random words, such as pattern or dither logic.

## Interface
- `N`, 32: sample width in bits.
- `RctCutoff`, 4: number of consecutive identical samples that declares an RCT failure. Must be ≥2.
- `AptWindow`, 512: APT window length in accepted samples. Must be ≥2.
- `AptCutoff`, 13: number of matches to the window reference, including the reference itself, that declares an APT failure. Must be ≥2 and ≤AptWindow.
- `Startup`, 1024: number of accepted samples that must pass both tests before forwarding starts. Must be ≥1.

Ports:
- `clk_i` in 1: single clock.
- `rstn_i` in 1: asynchronous active-low reset.
- `valid_i` in 1: `data_i` holds a new sample this cycle.
- `data_i` in N: raw sample.
- `clear_i` in 1: synchronous clear of the failure state; restarts startup.
- `valid_o` out 1: `data_o` holds a forwarded sample. Pulse, one cycle per sample.
- `data_o` out N: forwarded sample.
- `healthy_o` out 1: block is in RUN.
- `rct_fail_o` out 1: sticky RCT failure flag.
- `apt_fail_o` out 1: sticky APT failure flag.

## Operation
- A sample is accepted when `valid_i`=1, `clear_i`=0 and the state is not FAILED. Cycles with `valid_i`=0 change no counter.
- States are STARTUP, RUN and FAILED. Reset enters STARTUP.
- RCT:
  - Registers `last_r` and `rct_cnt`.
  - On an accepted sample, if `rct_cnt`≠0 and `data_i`==`last_r`, then `rct_cnt`←`rct_cnt`+1, saturating at RctCutoff. Otherwise `rct_cnt`←1.
  - `last_r`←`data_i` on every accepted sample.
  - `rct_hit` = (next `rct_cnt` == RctCutoff).
- APT:
  - `apt_idx` runs 0..AptWindow-1 and advances on each accepted sample, wrapping from AptWindow-1 to 0.
  - At `apt_idx`=0, `ref_r`←`data_i` and `apt_cnt`←1.
  - Otherwise, if `data_i`==`ref_r`, `apt_cnt`←`apt_cnt`+1, saturating at AptCutoff.
  - `apt_hit` = (next `apt_cnt` == AptCutoff).
  - Windows are aligned to the first accepted sample after reset or clear.
- `fail_now` = `rct_hit` | `apt_hit`, evaluated only for an accepted sample.
- Transitions:
  - STARTUP, `fail_now` → FAILED.
  - STARTUP, Startup-th accepted sample without failure → RUN. That sample is not forwarded.
  - RUN, `fail_now` → FAILED.
  - FAILED, `clear_i` → STARTUP.
  - Any state, `clear_i` → STARTUP. This resets all counters and `rct_cnt`, clears both fail flags, and clears the startup count.
- Forwarding: in RUN, an accepted sample with `fail_now`=0 produces `valid_o`=1 and `data_o`=`data_i` on the next cycle. The sample that triggers a failure is never forwarded.
- Both fail flags set together if both tests hit on the same sample.
- Priority: `clear_i` beats a same-cycle `valid_i`. That sample is dropped and is not counted by either test.
- Counter widths: `rct_cnt` is $clog2(RctCutoff+1) bits. `apt_cnt` and `apt_idx` are sized for AptCutoff and AptWindow-1. The startup counter is sized for Startup.

## Timing
- All outputs are registered. Latency from `valid_i` to `valid_o` is 1 cycle.
- Reset values: `valid_o`=0, `data_o`=0, `healthy_o`=0, `rct_fail_o`=0, `apt_fail_o`=0. All counters, `last_r` and `ref_r` are 0.
- `healthy_o` rises the cycle after the Startup-th sample edge.
- On the edge of the failing sample, `healthy_o` falls and the fail flags rise, both visible the next cycle.
- `data_o` holds its last value when `valid_o`=0.
- After `clear_i`, outputs are `healthy_o`=0 and both flags 0 the next cycle.
- Back-to-back samples are accepted every cycle with no bubbles.
- Reset mid-operation aborts immediately to reset values. No partial sample is forwarded.

## Test plan
Parameters for all tests: N=8, RctCutoff=3, AptWindow=8, AptCutoff=4, Startup=4.
- Reset: assert `rstn_i` asynchronously between edges → all outputs 0 immediately. `valid_o` stays 0 for any `valid_i` traffic until startup completes.
- Startup: samples 1,2,3,4 → no `valid_o`, `healthy_o`=1 the cycle after sample 4. Then sample 5 → `valid_o`=1 and `data_o`=5 one cycle later.
- RCT: in RUN, samples 9,9,9 → first two 9s forwarded, third not. `rct_fail_o`=1 and `healthy_o`=0 one cycle after the third 9. Further samples give no `valid_o`.
- APT: after startup with the window restarted, feed 0xA,1,0xA,2,0xA,3,0xA → failure on the 7th sample, `apt_fail_o`=1 and `rct_fail_o`=0. A variant 0xA,1,0xA,2,0xA,3,0xB,0xC followed by a new window 0xD,… → no failure across the wrap.
- Clear collision: in FAILED, assert `clear_i` together with `valid_i` (data 7) → flags 0, STARTUP entered, sample 7 not counted. Four further distinct samples are needed before `healthy_o`=1.
- Gapped input: samples 1,2,3,4,5 with 0–3 idle cycles between them → identical results to back-to-back input. Idle cycles never advance `rct_cnt`, `apt_idx` or the startup count.
